// File: rtl/rob_pkg.sv
// Constants and tag type shared by the ROB, its port arbiter and the test bench.
package rob_pkg;

  localparam int NPORTS   = 4;
  localparam int PORTW    = 2;
  localparam int ROB_SIZE = 16;
  localparam int SWIDTH   = 4;
  localparam int AWIDTH   = 40;
  localparam int DWIDTH   = 32;
  localparam int PWIDTH   = 32;
  localparam int IDWIDTH  = 16;

  typedef struct packed {
    logic [PORTW-1:0]   port;
    logic [IDWIDTH-1:0] id;
  } tag_t;

endpackage

// File: rtl/rob_rr_arb.sv
// Round-robin priority picker: first requester at or after ptr wins, unless a stalled grant is locked.
module rob_rr_arb #(
  parameter int NPORTS = 4,
  parameter int PORTW  = 2
) (
  input  logic [NPORTS-1:0] req,
  input  logic [PORTW-1:0]  ptr,
  input  logic              lock,
  input  logic [PORTW-1:0]  locked_port,
  output logic [PORTW-1:0]  grant,
  output logic              any
);

  logic             found;
  logic [PORTW:0]   idx;

  assign any = |req;

  always_comb begin
    grant = ptr;
    found = 1'b0;
    idx   = '0;
    if (lock) begin
      grant = locked_port;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        idx = {1'b0, ptr} + (PORTW+1)'(i);
        if (idx >= (PORTW+1)'(NPORTS)) begin
          idx = idx - (PORTW+1)'(NPORTS);
        end
        if (!found && req[idx[PORTW-1:0]]) begin
          grant = idx[PORTW-1:0];
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rob_port_arb.sv
// Shares one ROB among NPORTS requesters: round-robin request grant with sequential IDs,
// and a tag FIFO that steers the ROB's in-order responses back to the originating port.
module rob_port_arb
  import rob_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [NPORTS-1:0]        in_req_val,
  input  logic [NPORTS*AWIDTH-1:0] in_req_addr,
  input  logic [NPORTS*PWIDTH-1:0] in_req_param,
  output logic [NPORTS-1:0]        in_req_ready,
  output logic [NPORTS-1:0]        in_rsp_val,
  output logic [DWIDTH-1:0]        in_rsp_data,
  output logic [PWIDTH-1:0]        in_rsp_param,
  input  logic [NPORTS-1:0]        in_rsp_ready,
  output logic                     rob_req_val,
  output logic [AWIDTH-1:0]        rob_req_addr,
  output logic [IDWIDTH-1:0]       rob_req_ID,
  output logic [PWIDTH-1:0]        rob_req_param,
  input  logic                     rob_req_ready,
  input  logic                     rob_rsp_val,
  input  logic [DWIDTH-1:0]        rob_rsp_data,
  input  logic [IDWIDTH-1:0]       rob_rsp_ID,
  input  logic [PWIDTH-1:0]        rob_rsp_param,
  output logic                     rob_rsp_ready,
  output logic [SWIDTH:0]          outstanding,
  output logic                     err
);

  logic [PORTW-1:0]   rr_ptr;
  logic [PORTW-1:0]   locked_port;
  logic [PORTW-1:0]   grant;
  logic               lock;
  logic               any_req;
  logic [IDWIDTH-1:0] id_cnt;
  tag_t               tag_mem [ROB_SIZE];
  logic [SWIDTH-1:0]  wr_ptr;
  logic [SWIDTH-1:0]  rd_ptr;
  logic [SWIDTH:0]    count;
  tag_t               head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  rob_rr_arb #(
    .NPORTS(NPORTS),
    .PORTW (PORTW)
  ) u_arb (
    .req        (in_req_val),
    .ptr        (rr_ptr),
    .lock       (lock),
    .locked_port(locked_port),
    .grant      (grant),
    .any        (any_req)
  );

  assign full  = (count == (SWIDTH+1)'(ROB_SIZE));
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

  // Every val/ready output is gated by rst_ so nothing handshakes while reset is held.
  assign rob_req_val   = rst_ & any_req & ~full;
  assign rob_req_addr  = in_req_addr[int'(grant)*AWIDTH +: AWIDTH];
  assign rob_req_param = in_req_param[int'(grant)*PWIDTH +: PWIDTH];
  assign rob_req_ID    = id_cnt;
  assign push          = rob_req_val & rob_req_ready;

  assign rob_rsp_ready = rst_ & (empty ? rob_rsp_val : in_rsp_ready[head.port]);
  assign pop           = rob_rsp_val & rob_rsp_ready & ~empty;
  assign in_rsp_data   = rob_rsp_data;
  assign in_rsp_param  = rob_rsp_param;
  assign outstanding   = count;

  always_comb begin
    in_req_ready = '0;
    in_rsp_val   = '0;
    if (rst_) begin
      in_req_ready[grant]   = rob_req_ready & ~full;
      in_rsp_val[head.port] = rob_rsp_val & ~empty;
    end
  end

  // A stalled grant is pinned until its handshake so the presented fields cannot switch ports.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rr_ptr      <= '0;
      id_cnt      <= '0;
      lock        <= 1'b0;
      locked_port <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err         <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        id_cnt <= id_cnt + 1'b1;
        rr_ptr <= (grant == PORTW'(NPORTS-1)) ? '0 : grant + 1'b1;
        lock   <= 1'b0;
      end else if (rob_req_val) begin
        lock        <= 1'b1;
        locked_port <= grant;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if ((rob_rsp_val & empty) | (pop & (rob_rsp_ID != head.id))) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= '{port: grant, id: id_cnt};
    end
  end

endmodule
